// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, FSM state type and SCK edge-role selection for
// the oversampled SPI slave (spi_slave_sync) and its synchroniser.
package spi_pkg;

    // Depth of the metastability synchroniser on every SPI pin.
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Which synchronised SCK transition samples SIMO and which advances SOMI.
    typedef struct packed {
        logic sample_on_rise;
        logic shift_on_rise;
    } edge_sel_t;

    // Leading edge is the move away from CPOL; CPHA=0 samples on it,
    // CPHA=1 samples on the return to CPOL. Shifting uses the other edge.
    function automatic edge_sel_t edge_sel(input logic cpol, input logic cpha);
        edge_sel_t sel;
        sel.sample_on_rise = cpha ? cpol : ~cpol;
        sel.shift_on_rise  = ~sel.sample_on_rise;
        return sel;
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: word-level side of the SPI slave.
//   tx_data/tx_valid/tx_ready : transmit holding-register handshake
//   rx_data/rx_valid          : received word and its one-cycle strobe
// Modport slave is the SPI block, master is the register/command logic.
interface spi_slave_sync_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser followed by an edge-detect
// flop. level, rise and fall are all registered and mutually aligned, three
// clk cycles after the pin.
//   clk, rst  : system clock, synchronous active-high reset
//   din       : asynchronous pin
//   level     : synchronised pin level
//   rise/fall : one-cycle pulses, asserted in the cycle level changes
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchroniser chain plus edge detector; reset to the pin's idle level so
    // leaving reset never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            level  <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave with all pins oversampled in the clk domain.
//   clk, rst      : system clock (>= 8x SCK), synchronous active-high reset
//   SCK, SIMO, CS : SPI pins from the master (CS active low)
//   SOMI          : slave-out data, MSB first
//   bus           : spi_slave_sync_if.slave (tx holding register, rx strobe)
//   busy          : synchronised CS asserted
//   frame_err     : partial-word / underrun pulse, only when
//                   SPI_SLAVE_FRAME_ERR_EN is defined
// Parameters: WIDTH (4..32), CPOL, CPHA.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          CPOL  = 1'b0,
    parameter bit          CPHA  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCK,
    input  logic             SIMO,
    input  logic             CS,
    output logic             SOMI,
    spi_slave_sync_if.slave  bus,
    output logic             busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam edge_sel_t       SEL   = edge_sel(CPOL, CPHA);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic simo_level, simo_rise, simo_fall;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-2:0]   rx_shift;
    logic [WIDTH-1:0]   rx_data_q;
    logic               rx_valid_q;
    logic [WIDTH-1:0]   tx_shift;
    logic [WIDTH-1:0]   hold_data;
    logic               tx_ready_q;
    logic               somi_q;

    logic               sample_edge_c;
    logic               shift_edge_c;
    logic               word_done_c;
    logic [WIDTH-1:0]   load_word_c;
    logic [CNT_W-1:0]   cnt_next_c;
    logic               err_partial_c;
    logic               err_underrun_c;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (SCK),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (CS),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_simo (
        .clk   (clk),
        .rst   (rst),
        .din   (SIMO),
        .level (simo_level),
        .rise  (simo_rise),
        .fall  (simo_fall)
    );

    // Only the SCK/CS edges and the SIMO level are consumed.
    logic unused_edges;
    assign unused_edges = sck_level | cs_level | simo_rise | simo_fall;

    // Edge roles, word boundary and the word the transmit register would load.
    always_comb begin
        sample_edge_c = SEL.sample_on_rise ? sck_rise : sck_fall;
        shift_edge_c  = SEL.shift_on_rise  ? sck_rise : sck_fall;
        word_done_c   = (state == ACTIVE) && sample_edge_c && (cnt == LAST);
        load_word_c   = tx_ready_q ? '0 : hold_data;
        cnt_next_c    = cnt;
        if (sample_edge_c) begin
            cnt_next_c = word_done_c ? '0 : cnt + CNT_W'(1);
        end
        // Counter value after this cycle's sample decides whether CS rising
        // abandons a partial word.
        err_partial_c  = (state == ACTIVE) && cs_rise && (cnt_next_c != '0);
        err_underrun_c = word_done_c && tx_ready_q;
    end

    // Frame FSM with shift registers, holding register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_shift   <= '0;
            hold_data  <= '0;
            tx_ready_q <= 1'b1;
            somi_q     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            // A write needs an empty register and a load needs a full one, so
            // a write never collides with a load in the same cycle.
            if (bus.tx_valid && tx_ready_q) begin
                hold_data  <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt    <= '0;
                    somi_q <= 1'b0;
                    busy   <= 1'b0;
                    if (cs_fall) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                        if (!tx_ready_q) begin
                            tx_ready_q <= 1'b1;
                        end
                        // CPHA=0 drives the MSB before the first SCK edge;
                        // CPHA=1 waits for the first leading edge.
                        if (CPHA) begin
                            tx_shift <= load_word_c;
                        end else begin
                            tx_shift <= load_word_c << 1;
                            somi_q   <= load_word_c[WIDTH-1];
                        end
                    end
                end

                ACTIVE: begin
                    // tx_shift keeps the next bit to present in its MSB.
                    if (shift_edge_c) begin
                        somi_q   <= tx_shift[WIDTH-1];
                        tx_shift <= tx_shift << 1;
                    end
                    if (sample_edge_c) begin
                        rx_shift <= {rx_shift[WIDTH-3:0], simo_level};
                        cnt      <= cnt_next_c;
                        if (word_done_c) begin
                            rx_data_q  <= {rx_shift, simo_level};
                            rx_valid_q <= 1'b1;
                            tx_shift   <= load_word_c;
                            if (!tx_ready_q) begin
                                tx_ready_q <= 1'b1;
                            end
                        end
                    end
                    // Completion above is kept even when CS rises this cycle.
                    if (cs_rise) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        somi_q <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign SOMI         = somi_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // One-cycle pulse for a dropped partial word or a reload underrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_partial_c | err_underrun_c;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_partial_c | err_underrun_c;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed bench for spi_slave_sync. dut0 is mode 0 with
// WIDTH=8, dut3 is mode 3 with WIDTH=16. SCK half-period is H clk cycles.
module tb_spi_slave_sync;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic sck0, cs0, simo0, somi0, busy0;
    logic sck3, cs3, simo3, somi3, busy3;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic ferr0, ferr3;
`endif

    spi_slave_sync_if #(.WIDTH(8))  bus0 ();
    spi_slave_sync_if #(.WIDTH(16)) bus3 ();

    spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .SCK  (sck0),
        .SIMO (simo0),
        .CS   (cs0),
        .SOMI (somi0),
        .bus  (bus0),
        .busy (busy0)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err (ferr0)
`endif
    );

    spi_slave_sync #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .SCK  (sck3),
        .SIMO (simo3),
        .CS   (cs3),
        .SOMI (somi3),
        .bus  (bus3),
        .busy (busy3)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err (ferr3)
`endif
    );

    // Event monitors, sampled away from the active edge.
    int rxv0 = 0;
    int rxv3 = 0;
    int fe0  = 0;
    int fe3  = 0;
    logic [15:0] rxq3[$];

    always @(negedge clk) begin
        if (bus0.rx_valid === 1'b1) rxv0++;
        if (bus3.rx_valid === 1'b1) begin
            rxv3++;
            rxq3.push_back(bus3.rx_data);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (ferr0 === 1'b1) fe0++;
        if (ferr3 === 1'b1) fe3++;
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sck(input int d, input logic v);
        if (d == 0) sck0 = v; else sck3 = v;
    endtask

    task automatic set_simo(input int d, input logic v);
        if (d == 0) simo0 = v; else simo3 = v;
    endtask

    task automatic set_cs(input int d, input logic v);
        if (d == 0) cs0 = v; else cs3 = v;
    endtask

    function automatic logic get_somi(input int d);
        return (d == 0) ? somi0 : somi3;
    endfunction

    function automatic logic [31:0] q_at(input int idx);
        if (idx < rxq3.size()) return 32'(rxq3[idx]);
        return 'x;
    endfunction

    task automatic cs_low(input int d);
        set_cs(d, 1'b0);
        wclk(H);
    endtask

    task automatic cs_high(input int d);
        wclk(H);
        set_cs(d, 1'b1);
        wclk(H);
    endtask

    // Clock n bits MSB first; cs_last raises CS together with the last sample edge.
    task automatic spi_bits(input int d, input int n, input logic [31:0] mosi,
                            input bit cs_last, output logic [31:0] miso);
        logic cpol;
        logic cpha;
        cpol = (d == 3);
        cpha = (d == 3);
        miso = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                set_simo(d, mosi[i]);
                wclk(H);
                set_sck(d, ~cpol);
                miso = {miso[30:0], get_somi(d)};
                if (cs_last && i == 0) set_cs(d, 1'b1);
                wclk(H);
                set_sck(d, cpol);
            end else begin
                set_sck(d, ~cpol);
                set_simo(d, mosi[i]);
                wclk(H);
                set_sck(d, cpol);
                miso = {miso[30:0], get_somi(d)};
                wclk(H);
            end
        end
    endtask

    // Offer a word to the holding register until it is accepted (bounded).
    task automatic write_tx(input int d, input logic [15:0] data);
        bit done;
        done = 1'b0;
        if (d == 0) begin
            bus0.tx_data  = data[7:0];
            bus0.tx_valid = 1'b1;
        end else begin
            bus3.tx_data  = data;
            bus3.tx_valid = 1'b1;
        end
        for (int k = 0; k < 100 && !done; k++) begin
            done = (d == 0) ? bus0.tx_ready : bus3.tx_ready;
            @(negedge clk);
        end
        bus0.tx_valid = 1'b0;
        bus3.tx_valid = 1'b0;
        chk("tx_accept", 32'(done), 32'd1);
    endtask

    logic [31:0] m, ma, mb, m2;
    int r, f, n;

    initial begin
        sck0 = 1'b0; cs0 = 1'b1; simo0 = 1'b0;
        sck3 = 1'b1; cs3 = 1'b1; simo3 = 1'b0;
        bus0.tx_data = '0; bus0.tx_valid = 1'b0;
        bus3.tx_data = '0; bus3.tx_valid = 1'b0;
        wclk(4);

        // Reset values
        chk("rst_somi",     32'(somi0),         32'd0);
        chk("rst_tx_ready", 32'(bus0.tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(bus0.rx_valid), 32'd0);
        chk("rst_rx_data",  32'(bus0.rx_data),  32'd0);
        chk("rst_busy",     32'(busy0),         32'd0);
        chk("rst_busy3",    32'(busy3),         32'd0);
        rst = 1'b0;
        wclk(4);

        // Mode 0: slave sends 0xA5, master sends 0x3C
        write_tx(0, 16'h00A5);
        chk("m0_hold_full", 32'(bus0.tx_ready), 32'd0);
        r = rxv0;
        cs_low(0);
        chk("m0_busy",      32'(busy0),         32'd1);
        chk("m0_somi_msb",  32'(somi0),         32'd1);
        chk("m0_tx_ready",  32'(bus0.tx_ready), 32'd1);
        spi_bits(0, 8, 32'h3C, 1'b0, m);
        cs_high(0);
        chk("m0_rx_data",   32'(bus0.rx_data),  32'h3C);
        chk("m0_rx_pulses", 32'(rxv0 - r),      32'd1);
        chk("m0_miso",      m,                  32'hA5);
        chk("m0_idle_busy", 32'(busy0),         32'd0);
        chk("m0_idle_somi", 32'(somi0),         32'd0);

        // Underrun: nothing written, slave sends zeros
        r = rxv0; f = fe0;
        cs_low(0);
        spi_bits(0, 8, 32'h81, 1'b0, m);
        cs_high(0);
        chk("ur_miso",      m,                  32'h00);
        chk("ur_rx_data",   32'(bus0.rx_data),  32'h81);
        chk("ur_rx_pulses", 32'(rxv0 - r),      32'd1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        chk("ur_frame_err", 32'(fe0 - f),       32'd1);
`endif

        // Partial word of 5 bits is dropped
        r = rxv0; f = fe0;
        cs_low(0);
        spi_bits(0, 5, 32'h16, 1'b0, m);
        cs_high(0);
        chk("pw_rx_pulses", 32'(rxv0 - r),      32'd0);
        chk("pw_rx_hold",   32'(bus0.rx_data),  32'h81);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        chk("pw_frame_err", 32'(fe0 - f),       32'd1);
`endif
        write_tx(0, 16'h005A);
        r = rxv0;
        cs_low(0);
        spi_bits(0, 8, 32'hC3, 1'b0, m);
        cs_high(0);
        chk("pw_next_rx",   32'(bus0.rx_data),  32'hC3);
        chk("pw_next_cnt",  32'(rxv0 - r),      32'd1);
        chk("pw_next_miso", m,                  32'h5A);

        // CS rises together with the last sample edge: word still completes
        write_tx(0, 16'h006C);
        r = rxv0;
        cs_low(0);
        spi_bits(0, 8, 32'hE7, 1'b1, m);
        wclk(2 * H);
        chk("csl_rx_data",  32'(bus0.rx_data),  32'hE7);
        chk("csl_pulses",   32'(rxv0 - r),      32'd1);
        chk("csl_miso",     m,                  32'h6C);
        chk("csl_busy",     32'(busy0),         32'd0);

        // Reset at bit 3 of a word
        write_tx(0, 16'h0099);
        cs_low(0);
        spi_bits(0, 3, 32'h7, 1'b0, m);
        rst = 1'b1;
        cs0 = 1'b1;
        wclk(1);
        chk("mr_somi",      32'(somi0),         32'd0);
        chk("mr_tx_ready",  32'(bus0.tx_ready), 32'd1);
        chk("mr_rx_valid",  32'(bus0.rx_valid), 32'd0);
        chk("mr_rx_data",   32'(bus0.rx_data),  32'd0);
        chk("mr_busy",      32'(busy0),         32'd0);
        wclk(4);
        rst = 1'b0;
        sck0 = 1'b0;
        wclk(4);
        write_tx(0, 16'h003E);
        r = rxv0;
        cs_low(0);
        spi_bits(0, 8, 32'h71, 1'b0, m);
        cs_high(0);
        chk("mr_next_rx",   32'(bus0.rx_data),  32'h71);
        chk("mr_next_cnt",  32'(rxv0 - r),      32'd1);
        chk("mr_next_miso", m,                  32'h3E);

        // Mode 3, WIDTH=16: two-word frame, tx_valid held while holding is full
        write_tx(3, 16'hBEEF);
        chk("m3_hold_full", 32'(bus3.tx_ready), 32'd0);
        n = rxq3.size();
        cs_low(3);
        chk("m3_busy",      32'(busy3),         32'd1);
        write_tx(3, 16'h0F0F);
        bus3.tx_data  = 16'h7777;
        bus3.tx_valid = 1'b1;
        wclk(2);
        chk("m3_no_capture", 32'(bus3.tx_ready), 32'd0);
        spi_bits(3, 8, 32'h12, 1'b0, ma);
        chk("m3_mid_ready", 32'(bus3.tx_ready), 32'd0);
        spi_bits(3, 8, 32'h34, 1'b0, mb);
        spi_bits(3, 16, 32'hABCD, 1'b0, m2);
        bus3.tx_valid = 1'b0;
        cs_high(3);
        chk("m3_miso_w0",   {16'h0, ma[7:0], mb[7:0]}, 32'hBEEF);
        chk("m3_miso_w1",   m2,                 32'h0F0F);
        chk("m3_rx_count",  32'(rxq3.size() - n), 32'd2);
        chk("m3_rx_w0",     q_at(n),            32'h1234);
        chk("m3_rx_w1",     q_at(n + 1),        32'hABCD);
        chk("m3_rx_data",   32'(bus3.rx_data),  32'hABCD);
        chk("m3_idle_busy", 32'(busy3),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
